// File: rtl/id_ex_stage.sv
`default_nettype none
// ==== id_ex_stage: ID/EX pipeline register with operand forwarding and load-use detection -- rev 1.0 ====
module id_ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [WIDTH-1:0] id_rs1_val,
   input  logic [WIDTH-1:0] id_rs2_val,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [2:0]       id_alu_ctrl,
   input  logic             id_alu_src,
   input  logic             id_uses_rs2,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             exm_reg_write,
   input  logic [4:0]       exm_rd,
   input  logic [WIDTH-1:0] exm_result,
   input  logic             mwb_reg_write,
   input  logic [4:0]       mwb_rd,
   input  logic [WIDTH-1:0] mwb_result,
   input  logic             flush,
   input  logic             ex_stall,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_ctrl,
   output logic             ex_valid,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic [4:0]       ex_rd,
   output logic [WIDTH-1:0] ex_store_data,
   output logic             load_use_stall
);

   logic             ex_alu_src;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [WIDTH-1:0] ex_rs1_val;
   logic [WIDTH-1:0] ex_rs2_val;
   logic [WIDTH-1:0] ex_imm;
   logic [WIDTH-1:0] rs1_fwd;
   logic [WIDTH-1:0] rs2_fwd;

   // EX/MEM is the younger producer, so it is checked first.
   always_comb begin
      rs1_fwd = ex_rs1_val;
      rs2_fwd = ex_rs2_val;
      if (ex_valid) begin
         if (exm_reg_write && exm_rd != 5'd0 && exm_rd == ex_rs1)
            rs1_fwd = exm_result;
         else if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == ex_rs1)
            rs1_fwd = mwb_result;
         if (exm_reg_write && exm_rd != 5'd0 && exm_rd == ex_rs2)
            rs2_fwd = exm_result;
         else if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == ex_rs2)
            rs2_fwd = mwb_result;
      end
   end

   assign load_use_stall = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                           ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));
   assign id_ready       = !ex_stall && !load_use_stall && !flush;
   assign alu_a          = rs1_fwd;
   assign alu_b          = ex_alu_src ? ex_imm : rs2_fwd;
   assign ex_store_data  = rs2_fwd;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_rd        <= 5'd0;
         ex_rs1       <= 5'd0;
         ex_rs2       <= 5'd0;
         alu_ctrl     <= 3'b000;
         ex_rs1_val   <= '0;
         ex_rs2_val   <= '0;
         ex_imm       <= '0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_rd        <= 5'd0;
      end else if (ex_stall) begin
         // Capture forwarded operands so they survive the producer retiring.
         ex_rs1_val <= rs1_fwd;
         ex_rs2_val <= rs2_fwd;
      end else if (load_use_stall) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_rd        <= 5'd0;
      end else if (id_valid) begin
         ex_valid     <= 1'b1;
         ex_reg_write <= id_reg_write;
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
         ex_alu_src   <= id_alu_src;
         ex_rd        <= id_rd;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         alu_ctrl     <= id_alu_ctrl;
         ex_rs1_val   <= id_rs1_val;
         ex_rs2_val   <= id_rs2_val;
         ex_imm       <= id_imm;
      end else begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ==== tb_id_ex_stage: scoreboard bench for id_ex_stage with a cycle-level reference model -- rev 1.0 ====
module tb_id_ex_stage;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic             rst_n, id_valid, src, u2, rw, mr, mw, exm_rw, mwb_rw, flush, stall;
      logic [4:0]       rs1, rs2, rd, exm_rd, mwb_rd;
      logic [2:0]       op;
      logic [WIDTH-1:0] v1, v2, imm, exm_res, mwb_res;
   } stim_t;

   typedef struct packed {
      logic             v, rw, mr, mw, src, rd_known, dk;
      logic [4:0]       rd, rs1, rs2;
      logic [2:0]       op;
      logic [WIDTH-1:0] a, b, imm;
   } model_t;

   typedef struct packed {
      logic             ready, lus, v, rw, mr, mw, rd_known, dk;
      logic [4:0]       rd;
      logic [2:0]       op;
      logic [WIDTH-1:0] a, b, st;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n, id_valid, id_ready, id_alu_src, id_uses_rs2, id_reg_write;
   logic             id_mem_read, id_mem_write, exm_reg_write, mwb_reg_write, flush, ex_stall;
   logic [4:0]       id_rs1, id_rs2, id_rd, exm_rd, mwb_rd, ex_rd;
   logic [WIDTH-1:0] id_rs1_val, id_rs2_val, id_imm, exm_result, mwb_result;
   logic [2:0]       id_alu_ctrl, alu_ctrl;
   logic [WIDTH-1:0] alu_a, alu_b, ex_store_data;
   logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

   int     vectors    = 0;
   int     miscompares = 0;
   exp_t   q[$];
   model_t m;

   always #5 clk = ~clk;

   id_ex_stage #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
      .flush(flush), .ex_stall(ex_stall),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
      .load_use_stall(load_use_stall)
   );

   function automatic stim_t idle();
      stim_t s = '0;
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic stim_t load(input logic [4:0] rs1, input logic [WIDTH-1:0] v1,
                                  input logic [4:0] rs2, input logic [WIDTH-1:0] v2,
                                  input logic [4:0] rd, input logic [2:0] op);
      stim_t s = idle();
      s.id_valid = 1'b1; s.rs1 = rs1; s.v1 = v1; s.rs2 = rs2; s.v2 = v2;
      s.rd = rd; s.op = op; s.u2 = 1'b1; s.rw = 1'b1;
      return s;
   endfunction

   // Value the held operand at register index idx should present this cycle.
   function automatic logic [WIDTH-1:0] fwd(input stim_t s, input logic [4:0] idx,
                                            input logic [WIDTH-1:0] stored);
      if (!m.v) return stored;
      if (s.exm_rw && s.exm_rd != 0 && s.exm_rd == idx) return s.exm_res;
      if (s.mwb_rw && s.mwb_rd != 0 && s.mwb_rd == idx) return s.mwb_res;
      return stored;
   endfunction

   task automatic step(input stim_t s);
      exp_t       e;
      logic       lus;
      logic [WIDTH-1:0] f1, f2;
      @(negedge clk);
      rst_n = s.rst_n; id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
      id_rs1_val = s.v1; id_rs2_val = s.v2; id_imm = s.imm; id_alu_ctrl = s.op;
      id_alu_src = s.src; id_uses_rs2 = s.u2; id_reg_write = s.rw; id_mem_read = s.mr;
      id_mem_write = s.mw; exm_reg_write = s.exm_rw; exm_rd = s.exm_rd; exm_result = s.exm_res;
      mwb_reg_write = s.mwb_rw; mwb_rd = s.mwb_rd; mwb_result = s.mwb_res;
      flush = s.flush; ex_stall = s.stall;
      #1;
      lus = m.v && m.mr && m.rd != 0 && s.id_valid &&
            (s.rs1 == m.rd || (s.u2 && s.rs2 == m.rd));
      f1 = fwd(s, m.rs1, m.a);
      f2 = fwd(s, m.rs2, m.b);
      e = '{ready: !s.stall && !lus && !s.flush, lus: lus, v: m.v, rw: m.rw, mr: m.mr,
            mw: m.mw, rd_known: m.rd_known, dk: m.dk, rd: m.rd, op: m.op,
            a: f1, b: (m.src ? m.imm : f2), st: f2};
      q.push_back(e);
      // Advance the model to its post-edge state.
      if (!s.rst_n) begin
         m = '0; m.rd_known = 1'b1; m.dk = 1'b1;
      end else if (s.flush) begin
         m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.src = 0; m.rd = 0; m.rd_known = 1; m.dk = 0;
      end else if (s.stall) begin
         m.a = f1; m.b = f2;
      end else if (lus) begin
         m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.rd = 0; m.rd_known = 1; m.dk = 0;
      end else if (s.id_valid) begin
         m = '{v: 1, rw: s.rw, mr: s.mr, mw: s.mw, src: s.src, rd_known: 1, dk: 1,
               rd: s.rd, rs1: s.rs1, rs2: s.rs2, op: s.op, a: s.v1, b: s.v2, imm: s.imm};
      end else begin
         m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.rd_known = 0; m.dk = 0;
      end
   endtask

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: compares every queued expectation against the live outputs.
   always @(negedge clk) begin
      #3;
      while (q.size() > 0) begin
         exp_t e;
         logic bad;
         e = q.pop_front();
         bad = 1'b0;
         vectors++;
         if (id_ready !== e.ready || load_use_stall !== e.lus || ex_valid !== e.v ||
             ex_reg_write !== e.rw || ex_mem_read !== e.mr || ex_mem_write !== e.mw) begin
            bad = 1'b1;
            $display("FAIL ctrl @%0t: got rdy=%b lus=%b v=%b rw=%b mr=%b mw=%b expected %b %b %b %b %b %b",
                     $time, id_ready, load_use_stall, ex_valid, ex_reg_write, ex_mem_read,
                     ex_mem_write, e.ready, e.lus, e.v, e.rw, e.mr, e.mw);
         end
         if (e.rd_known && ex_rd !== e.rd) begin
            bad = 1'b1;
            $display("FAIL ex_rd @%0t: got %0d expected %0d", $time, ex_rd, e.rd);
         end
         if (e.dk && (alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.st || alu_ctrl !== e.op)) begin
            bad = 1'b1;
            $display("FAIL data @%0t: got a=%h b=%h st=%h op=%0d expected a=%h b=%h st=%h op=%0d",
                     $time, alu_a, alu_b, ex_store_data, alu_ctrl, e.a, e.b, e.st, e.op);
         end
         if (bad) miscompares++;
      end
   end

   initial begin
      stim_t s;
      m = '0;
      s = idle(); s.rst_n = 1'b0;
      step(s); step(s);
      step(idle());
      check("reset_alu_a", alu_a, 0);
      check("reset_alu_b", alu_b, 0);
      check("reset_store", ex_store_data, 0);
      check("reset_lus", {31'd0, load_use_stall}, 0);

      // ADD x1(5) + x2(7)
      step(load(5'd1, 32'd5, 5'd2, 32'd7, 5'd6, 3'b000));
      step(idle());
      check("add_valid", {31'd0, ex_valid}, 1);
      check("add_a", alu_a, 5);
      check("add_b", alu_b, 7);
      check("add_ctrl", {29'd0, alu_ctrl}, 0);

      // Forwarding priority on held rs1=x3
      step(load(5'd3, 32'h99, 5'd2, 32'd1, 5'd7, 3'b010));
      s = idle(); s.stall = 1; s.exm_rw = 1; s.exm_rd = 3; s.exm_res = 32'h10;
      s.mwb_rw = 1; s.mwb_rd = 3; s.mwb_res = 32'h20;
      step(s);
      check("fwd_exm_wins", alu_a, 32'h10);
      s.exm_rd = 0;
      step(s);
      check("fwd_mwb", alu_a, 32'h20);

      // Hold persistence: mwb forwards 0xAA once, then retires
      step(load(5'd5, 32'h1, 5'd0, 32'h0, 5'd8, 3'b011));
      s = idle(); s.stall = 1; s.mwb_rw = 1; s.mwb_rd = 5; s.mwb_res = 32'hAA;
      step(s);
      check("hold1_a", alu_a, 32'hAA);
      check("hold1_ready", {31'd0, id_ready}, 0);
      s = idle(); s.stall = 1;
      for (int i = 0; i < 2; i++) begin
         step(s);
         check("hold_a", alu_a, 32'hAA);
         check("hold_ready", {31'd0, id_ready}, 0);
      end

      // Load-use: LW x4 then SUB using x4 as rs2
      s = load(5'd1, 32'd0, 5'd0, 32'd0, 5'd4, 3'b000); s.mr = 1; s.u2 = 0;
      step(s);
      s = load(5'd2, 32'd3, 5'd4, 32'd9, 5'd5, 3'b001);
      step(s);
      check("lu_stall", {31'd0, load_use_stall}, 1);
      check("lu_ready", {31'd0, id_ready}, 0);
      step(s);
      check("lu_bubble", {31'd0, ex_valid}, 0);
      step(idle());
      check("lu_sub_valid", {31'd0, ex_valid}, 1);
      check("lu_sub_ctrl", {29'd0, alu_ctrl}, 1);

      // Index 0 never forwards
      step(load(5'd0, 32'h55, 5'd0, 32'h66, 5'd0, 3'b100));
      s = idle(); s.exm_rw = 1; s.exm_rd = 0; s.exm_res = 32'hDEAD;
      step(s);
      check("x0_no_fwd", alu_a, 32'h55);

      // Flush beats stall and incoming instruction
      step(load(5'd1, 32'd1, 5'd2, 32'd2, 5'd9, 3'b000));
      s = load(5'd3, 32'd3, 5'd4, 32'd4, 5'd10, 3'b000); s.flush = 1; s.stall = 1;
      step(s);
      step(idle());
      check("flush_valid", {31'd0, ex_valid}, 0);
      check("flush_rw", {31'd0, ex_reg_write}, 0);
      check("flush_rd", {27'd0, ex_rd}, 0);

      // Reset during hold
      step(load(5'd1, 32'h77, 5'd2, 32'h88, 5'd11, 3'b101));
      s = idle(); s.stall = 1;
      step(s);
      s.rst_n = 0;
      step(s);
      step(idle());
      check("rst_hold_valid", {31'd0, ex_valid}, 0);
      check("rst_hold_a", alu_a, 0);
      check("rst_hold_b", alu_b, 0);
      check("rst_hold_rd", {27'd0, ex_rd}, 0);

      for (int i = 0; i < 400; i++) begin
         s.rst_n   = ($urandom_range(0, 63) != 0);
         s.id_valid = ($urandom_range(0, 3) != 0);
         s.flush   = ($urandom_range(0, 15) == 0);
         s.stall   = ($urandom_range(0, 3) == 0);
         s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
         s.rd  = 5'($urandom_range(0, 7));
         s.v1 = $urandom; s.v2 = $urandom; s.imm = $urandom;
         s.op = 3'($urandom_range(0, 7));
         s.src = 1'($urandom); s.u2 = 1'($urandom); s.rw = 1'($urandom);
         s.mr = 1'($urandom); s.mw = 1'($urandom);
         s.exm_rw = 1'($urandom); s.mwb_rw = 1'($urandom);
         s.exm_rd = 5'($urandom_range(0, 7)); s.mwb_rd = 5'($urandom_range(0, 7));
         s.exm_res = $urandom; s.mwb_res = $urandom;
         step(s);
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #5;
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
